// File: rtl/mx11_sequencer.sv
// mx11_sequencer: MX11 fetch/decode sequencer feeding the SEU.
// Ports: start/halted/illegal, imem req/ack bus, flags in, SEU bundle, imm load strobe.
module mx11_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  ZERO_BIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                halted,
  output logic                illegal,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  input  logic [7:0]          flags,
  output logic [3:0]          opcode,
  output logic [3:0]          src_a,
  output logic [3:0]          src_b,
  output logic [3:0]          dst_f,
  output logic                fetch,
  output logic                cs_n,
  output logic                imm_valid,
  output logic [3:0]          imm_dst,
  output logic [7:0]          imm_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_FETCH_OP,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;

  logic [3:0] ir_sub;
  logic       is_alu;
  logic       sys_halt;
  logic       sys_op;
  logic       sys_ill;
  logic       sub_ldi;
  logic       sub_jmp;
  logic       unused_flags;

  assign ir_sub   = ir[7:4];
  assign is_alu   = (ir[15:12] != 4'd0);
  // System decode is gated by !is_alu so the
  // DECODE selector stays one-hot.
  assign sys_halt = !is_alu && (ir_sub == 4'd1);
  assign sys_op   = !is_alu && (ir_sub >= 4'd2)
                    && (ir_sub <= 4'd4);
  assign sys_ill  = !is_alu && (ir_sub >= 4'd5);
  assign sub_ldi  = (ir_sub == 4'd2);
  assign sub_jmp  = (ir_sub == 4'd3);

  assign unused_flags = ^flags;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu:   state_nx = S_EXEC;
          sys_halt: state_nx = S_HALT;
          sys_op:   state_nx = S_FETCH_OP;
          default:  state_nx = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_nx = S_FETCH;
      end
      S_FETCH_OP: begin
        if (imem_ack) state_nx = S_FETCH;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    halted    = (state == S_IDLE)
             || (state == S_HALT);
    imem_req  = (state == S_FETCH)
             || (state == S_FETCH_OP);
    fetch     = imem_req;
    cs_n      = (state != S_EXEC);
    illegal   = (state == S_DECODE) && sys_ill;
    imem_addr = pc;
  end

  // PC, IR, SEU bundle and immediate port.
  // SEU fields are loaded while leaving DECODE
  // so they are valid in EXEC and hold after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ir        <= '0;
      opcode    <= '0;
      dst_f     <= '0;
      src_a     <= '0;
      src_b     <= '0;
      imm_valid <= 1'b0;
      imm_dst   <= '0;
      imm_data  <= '0;
    end else begin
      imm_valid <= 1'b0;
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + 1'b1;
      end
      if (state == S_DECODE && is_alu) begin
        opcode <= ir[15:12];
        dst_f  <= ir[11:8];
        src_a  <= ir[7:4];
        src_b  <= ir[3:0];
      end
      if (state == S_FETCH_OP && imem_ack) begin
        unique case (1'b1)
          sub_ldi: begin
            imm_valid <= 1'b1;
            imm_dst   <= ir[11:8];
            imm_data  <= imem_rdata[7:0];
            pc        <= pc + 1'b1;
          end
          sub_jmp: begin
            pc <= imem_rdata[PC_WIDTH-1:0];
          end
          default: begin
            if (flags[ZERO_BIT]) begin
              pc <= imem_rdata[PC_WIDTH-1:0];
            end else begin
              pc <= pc + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
